// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the RV64 datapath: FETCH/FWAIT/DECODE/EXEC/MEM/WB
// with halt at instruction boundaries, trap on illegal opcode, ecall/ebreak or memory timeout.
module cpu_sequencer #(
    parameter int IMEM_LATENCY = 1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             imem_en,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_FWAIT  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
    localparam logic [1:0] CAUSE_ECALL   = 2'd3;

    localparam logic [1:0] LAT_INIT = 2'(IMEM_LATENCY - 1);
    localparam logic [7:0] TO_LAST  = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [1:0]       lat_q, lat_d;
    logic [7:0]       to_q, to_d;
    logic [1:0]       cause_q, cause_d;
    logic             is_load_q, is_load_d;
    logic             is_store_q, is_store_d;
    logic             no_rf_q, no_rf_d;
    logic [CNT_W-1:0] retired_q;
    logic             op_legal;

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b0011011, 7'b0111011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    end

    // State register plus the small side registers that travel with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            lat_q      <= 2'd0;
            to_q       <= 8'd0;
            cause_q    <= 2'd0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            no_rf_q    <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            to_q       <= to_d;
            cause_q    <= cause_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            no_rf_q    <= no_rf_d;
            if (state_q == S_WB) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        to_d       = to_q;
        cause_d    = cause_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;
        no_rf_d    = no_rf_q;
        case (state_q)
            S_FETCH: begin
                state_d = S_FWAIT;
                lat_d   = LAT_INIT;
            end
            S_FWAIT: begin
                if (lat_q != 2'd0) begin
                    lat_d = lat_q - 2'd1;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Opcode class is captured here so later states do not depend on the IR staying put.
                is_load_d  = (opcode == OP_LOAD);
                is_store_d = (opcode == OP_STORE);
                no_rf_d    = (opcode == OP_STORE) || (opcode == OP_BRANCH);
                if (opcode == OP_SYSTEM) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ECALL;
                end else if (!op_legal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                to_d    = 8'd0;
                state_d = (is_load_q || is_store_q) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // A ready arriving on the final allowed cycle still completes the access.
                if (mem_ready) begin
                    state_d = S_WB;
                end else if (to_q == TO_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    to_d = to_q + 8'd1;
                end
            end
            S_WB: begin
                state_d = halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (resume && !halt_req) begin
                    state_d = S_FETCH;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Outputs are decoded from state only; reset masks them so FETCH shows no enable while held.
    always_comb begin
        imem_en = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        rf_we   = 1'b0;
        dmem_re = 1'b0;
        dmem_we = 1'b0;
        halted  = 1'b0;
        trap    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: imem_en = 1'b1;
                S_FWAIT: ir_we   = (lat_q == 2'd0);
                S_MEM: begin
                    dmem_re = is_load_q;
                    dmem_we = is_store_q;
                end
                S_WB: begin
                    pc_we = 1'b1;
                    rf_we = !no_rf_q;
                end
                S_HALT:  halted = 1'b1;
                S_TRAP:  trap   = 1'b1;
                default: ;
            endcase
        end
    end

    assign trap_cause = cause_q;
    assign state      = state_q;
    assign retired    = retired_q;

    a_enable_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0({imem_en, ir_we, pc_we, dmem_re, dmem_we}));
    a_rf_with_pc: assert property (@(posedge clk) disable iff (reset) rf_we |-> pc_we);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: per-cycle expected output vectors are queued alongside stimulus
// and compared against the DUT every cycle; a second instance covers IMEM_LATENCY=3.
module tb_cpu_sequencer;

    localparam int W       = 45;
    localparam int TIMEOUT = 16;

    localparam logic [2:0] S_FETCH = 3'd0, S_FWAIT = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_TRAP = 3'd7;

    localparam logic [7:0] E_IMEM = 8'h80, E_IR = 8'h40, E_PC = 8'h20, E_RF = 8'h10;
    localparam logic [7:0] E_RE = 8'h08, E_WE = 8'h04, E_HALT = 8'h02, E_TRAP = 8'h01;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  opcode;
    logic        mem_ready, halt_req, resume;

    logic        imem_en_a, ir_we_a, pc_we_a, rf_we_a, dmem_re_a, dmem_we_a, halted_a, trap_a;
    logic [1:0]  trap_cause_a;
    logic [2:0]  state_a;
    logic [31:0] retired_a;
    logic        imem_en_b, ir_we_b, pc_we_b, rf_we_b, dmem_re_b, dmem_we_b, halted_b, trap_b;
    logic [1:0]  trap_cause_b;
    logic [2:0]  state_b;
    logic [31:0] retired_b;

    logic [W-1:0] exp_q[$];
    logic [9:0]   stim_q[$];
    logic [31:0]  exp_ret;
    int           n_vec = 0;
    int           n_bad = 0;

    logic [6:0] legal_ops [11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                   7'b0011011, 7'b0111011, 7'b1100011, 7'b1101111,
                                   7'b1100111, 7'b0110111, 7'b0010111};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    cpu_sequencer #(.IMEM_LATENCY(1), .MEM_TIMEOUT(TIMEOUT), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .halt_req(halt_req), .resume(resume),
        .imem_en(imem_en_a), .ir_we(ir_we_a), .pc_we(pc_we_a), .rf_we(rf_we_a),
        .dmem_re(dmem_re_a), .dmem_we(dmem_we_a), .halted(halted_a), .trap(trap_a),
        .trap_cause(trap_cause_a), .state(state_a), .retired(retired_a)
    );

    cpu_sequencer #(.IMEM_LATENCY(3), .MEM_TIMEOUT(TIMEOUT), .CNT_W(32)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .halt_req(halt_req), .resume(resume),
        .imem_en(imem_en_b), .ir_we(ir_we_b), .pc_we(pc_we_b), .rf_we(rf_we_b),
        .dmem_re(dmem_re_b), .dmem_we(dmem_we_b), .halted(halted_b), .trap(trap_b),
        .trap_cause(trap_cause_b), .state(state_b), .retired(retired_b)
    );

    wire logic [W-1:0] obs_a = {state_a, imem_en_a, ir_we_a, pc_we_a, rf_we_a, dmem_re_a,
                                dmem_we_a, halted_a, trap_a, trap_cause_a, retired_a};
    wire logic [W-1:0] obs_b = {state_b, imem_en_b, ir_we_b, pc_we_b, rf_we_b, dmem_re_b,
                                dmem_we_b, halted_b, trap_b, trap_cause_b, retired_b};

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got st=%0d en=%b cause=%0d ret=%0d, expected st=%0d en=%b cause=%0d ret=%0d",
                     tag, got[44:42], got[41:34], got[33:32], got[31:0],
                     exp[44:42], exp[41:34], exp[33:32], exp[31:0]);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [7:0] en,
                                        input logic [1:0] cs);
        return {st, en, cs, exp_ret};
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push(input logic [6:0] op, input logic rdy, input logic hq,
                        input logic rs, input logic [W-1:0] e);
        stim_q.push_back({op, rdy, hq, rs});
        exp_q.push_back(e);
    endtask

    task automatic push_trap(input logic [6:0] op, input logic [1:0] cs);
        repeat (3) push(op, 1'b0, 1'b0, 1'b1, mk(S_TRAP, E_TRAP, cs));
    endtask

    // hq_mode: 0 none, 1 halt_req from EXEC through WB, 2 halt_req only during FETCH..DECODE
    task automatic push_instr(input logic [6:0] op, input int lat, input int ready_on,
                              input int hq_mode);
        logic early, late;
        bit   is_ld, is_st, is_mem, done;
        early  = (hq_mode == 2);
        late   = (hq_mode == 1);
        is_ld  = (op == OP_LOAD);
        is_st  = (op == OP_STORE);
        is_mem = is_ld || is_st;
        push(op, 1'b0, early, 1'b0, mk(S_FETCH, E_IMEM, 2'd0));
        for (int i = 1; i <= lat; i++)
            push(op, 1'b0, early, 1'b0, mk(S_FWAIT, (i == lat) ? E_IR : 8'h00, 2'd0));
        push(op, 1'b0, early, 1'b0, mk(S_DECODE, 8'h00, 2'd0));
        if (op == OP_SYSTEM) begin
            push_trap(op, 2'd3);
            return;
        end
        if (!is_legal(op)) begin
            push_trap(op, 2'd1);
            return;
        end
        push(op, 1'b0, late, 1'b0, mk(S_EXEC, 8'h00, 2'd0));
        if (is_mem) begin
            done = 1'b0;
            for (int k = 1; k <= TIMEOUT && !done; k++) begin
                push(op, (k == ready_on), late, 1'b0, mk(S_MEM, is_ld ? E_RE : E_WE, 2'd0));
                done = (k == ready_on);
            end
            if (!done) begin
                push_trap(op, 2'd2);
                return;
            end
        end
        push(op, 1'b0, late, 1'b0,
             mk(S_WB, E_PC | ((is_st || op == OP_BRANCH) ? 8'h00 : E_RF), 2'd0));
        exp_ret++;
    endtask

    task automatic push_halt_resume();
        repeat (2) push(OP_ALU, 1'b0, 1'b1, 1'b0, mk(S_HALT, E_HALT, 2'd0));
        repeat (2) push(OP_ALU, 1'b0, 1'b1, 1'b1, mk(S_HALT, E_HALT, 2'd0));
        push(OP_ALU, 1'b0, 1'b0, 1'b1, mk(S_HALT, E_HALT, 2'd0));
    endtask

    // Entered at a falling edge; applies each queued cycle and compares mid-cycle.
    task automatic drain(input bit sel, input string tag);
        logic [9:0] s;
        int         cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {opcode, mem_ready, halt_req, resume} = s;
            #1;
            check($sformatf("%s[%0d]", tag, cyc), sel ? obs_b : obs_a, exp_q.pop_front());
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_a", obs_a, '0);
        check("reset_b", obs_b, '0);
        @(negedge clk);
        reset    = 1'b0;
        exp_ret  = '0;
        exp_q.delete();
        stim_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [6:0] op;
        opcode = 7'd0; mem_ready = 1'b0; halt_req = 1'b0; resume = 1'b0;
        exp_ret = '0;
        reset = 1'b1;
        apply_reset();

        repeat (3) push_instr(OP_ALU, 1, 0, 0);
        push_instr(OP_LOAD, 1, 3, 0);
        push_instr(OP_BRANCH, 1, 0, 1);
        push_halt_resume();
        push_instr(OP_ALUI, 1, 0, 2);
        push_instr(OP_STORE, 1, TIMEOUT, 0);
        push_instr(OP_LOAD, 1, 1, 0);
        repeat (6) begin
            op = legal_ops[$urandom_range(0, 10)];
            push_instr(op, 1, $urandom_range(1, 6), 0);
        end
        drain(1'b0, "main");

        apply_reset();
        push_instr(7'b0000000, 1, 0, 0);
        drain(1'b0, "illegal");

        apply_reset();
        push_instr(OP_SYSTEM, 1, 0, 0);
        drain(1'b0, "ecall");

        apply_reset();
        push_instr(OP_ALU, 1, 0, 0);
        push_instr(OP_STORE, 1, 0, 0);
        drain(1'b0, "timeout");

        apply_reset();
        push_instr(OP_ALU, 3, 0, 0);
        push_instr(OP_LOAD, 3, 2, 0);
        drain(1'b1, "lat3");

        // Reset raised mid-cycle while dut_b waits on the instruction BRAM.
        apply_reset();
        opcode = OP_ALU;
        @(negedge clk);
        #1;
        check("lat3_fwait", obs_b, {S_FWAIT, 8'h00, 2'd0, 32'd0});
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_b", obs_b, '0);
        check("async_rst_a", obs_a, '0);
        @(negedge clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the RV64 datapath. It steps each instruction through fetch, decode, execute, optional memory access and writeback. It emits one-cycle enables for the PC register, the instruction register and register-file write. It holds data-memory read/write strobes until the memory handshakes, and it covers the synchronous-read latency of the instruction BRAM. It also provides halt/resume at instruction boundaries, an illegal-opcode or memory-timeout trap, and a retired-instruction counter.

Parameters:
IMEM_LATENCY, 1, instruction BRAM read latency in cycles (1..4).
MEM_TIMEOUT, 16, max cycles in MEM without mem_ready before trapping (2..255).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  7  instruction[6:0] from the instruction register, valid from DECODE onward
mem_ready  input  1  data memory has completed the current access (level, sampled in MEM)
halt_req  input  1  request to stop at the next instruction boundary (level)
resume  input  1  leave HALT (level)
imem_en  output  1  instruction BRAM read enable
ir_we  output  1  latch BRAM douta into the instruction register
pc_we  output  1  load pc_next into the PC
rf_we  output  1  register-file write enable (ANDed with RegWrite by the datapath)
dmem_re  output  1  data memory read strobe
dmem_we  output  1  data memory write strobe
halted  output  1  sequencer is in HALT
trap  output  1  sequencer is in TRAP
trap_cause  output  2  0 none, 1 illegal opcode, 2 memory timeout, 3 ecall/ebreak
state  output  3  current state encoding, for debug
retired  output  CNT_W  count of retired instructions

Behaviour:
- Reset (asynchronous, active-high): state=FETCH. All outputs are 0, including retired and trap_cause. Reset asserted mid-instruction aborts it immediately; no partial writeback.
- State encodings: FETCH=0, FWAIT=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7.
- FETCH: imem_en=1 for 1 cycle, then go to FWAIT. The FWAIT latency counter is loaded with IMEM_LATENCY-1.
- FWAIT: stay while the counter is nonzero, decrementing. When it is 0, ir_we=1 for 1 cycle and go to DECODE.
- DECODE: classify opcode.
  - Legal set: 0000011 load, 0100011 store, 0110011, 0010011, 0011011, 0111011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - 1110011 goes to TRAP with cause 3.
  - Any other opcode goes to TRAP with cause 1.
  - Legal opcodes go to EXEC.
- EXEC: 1 cycle. Load/store go to MEM; all others go to WB.
- MEM:
  - dmem_re (load) or dmem_we (store) is held high every cycle in MEM.
  - The timeout counter starts at 0 on entry and increments each cycle that mem_ready=0.
  - mem_ready=1 deasserts the strobe on the next cycle and goes to WB.
  - If the counter reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP with cause 2.
  - mem_ready in the same cycle as the timeout hit: ready wins.
- WB:
  - pc_we=1 for 1 cycle.
  - rf_we=1 for 1 cycle, except store and branch (0100011, 1100011), where rf_we=0.
  - retired increments by 1 and wraps modulo 2^CNT_W.
  - Next state is HALT if halt_req=1, else FETCH.
- Cycle counts per instruction with IMEM_LATENCY=1:
  - ALU, branch and jump: 5 cycles.
  - Load/store with immediate ready: 6 cycles.
  - Each mem_ready wait cycle adds 1.
- halt_req outside WB has no effect until the current instruction's WB. It is never an abort.
- HALT: halted=1 and no enables are asserted. resume=1 with halt_req=0 goes to FETCH next cycle. If resume and halt_req are both 1, stay in HALT.
- TRAP: trap=1 and trap_cause is held. No enables, no PC update, retired frozen. Only reset leaves TRAP.
- Enable exclusivity: at most one of imem_en, ir_we, pc_we, dmem_re, dmem_we is high in any cycle. rf_we is only ever high together with pc_we.

Test Plan:
- Reset then opcode=0110011 held, mem_ready=0 -> states 0,1,2,3,5 repeating. pc_we and rf_we pulse every 5th cycle. retired=3 after 15 cycles.
- Load 0000011, mem_ready asserted on the 3rd MEM cycle -> dmem_re high for exactly 3 cycles, WB on the next cycle, rf_we=1, instruction takes 8 cycles.
- Store 0100011, mem_ready never asserted, MEM_TIMEOUT=16 -> dmem_we high 16 cycles, then trap=1, trap_cause=2, retired unchanged. Reset clears trap.
- Opcode 0000000 -> TRAP cause 1 in the cycle after DECODE. Opcode 1110011 -> TRAP cause 3. Neither pulses pc_we.
- halt_req raised during EXEC of a branch 1100011 -> WB with pc_we=1 and rf_we=0, then HALT. resume with halt_req=1 stays halted; dropping halt_req -> FETCH next cycle.
- IMEM_LATENCY=3 with an ALU opcode -> ir_we 3 cycles after imem_en, 7-cycle instruction. Reset asserted during FWAIT -> state=0 and all outputs 0 asynchronously.
